msi_snoop_fsm: RTL and testbench
================================

MSI_SNOOP_FSM -- requirements
Module: msi_snoop_fsm

Interface
REQ-001 SHALL have parameter PROC_W, default 2, processor-index width.
REQ-002 SHALL have parameter DATA_W, default 8, cache-line data width.
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port req_active, input, 1, requester-side evaluate strobe.
REQ-006 SHALL have port cpu_action, input, 3, 001 read hit, 010 read miss, 011 write hit, 100 write miss.
REQ-007 SHALL have port req_state, input, 2, current local line state: 00 I, 01 S, 10 M.
REQ-008 SHALL have port req_proc, input, PROC_W, index of the issuing processor.
REQ-009 SHALL have port req_wb, output, 1, requester must write back its old line.
REQ-010 SHALL have port req_next_state, output, 2, new local state.
REQ-011 SHALL have port bus_msg, output, 3, 000 none, 001 read miss, 010 write miss, 011 invalidate.
REQ-012 SHALL have port req_proc_out, output, PROC_W, registered req_proc.
REQ-013 SHALL have port snp_active, input, 1, snooper-side evaluate strobe.
REQ-014 SHALL have port snp_cache_hit, input, 1, snooped tag matches a local line.
REQ-015 SHALL have port snp_state, input, 2, state of the matched local line.
REQ-016 SHALL have port snp_proc, input, PROC_W, index of the processor originating bus_msg_in.
REQ-017 SHALL have port bus_msg_in, input, 3, bus message on the bus; same encoding as bus_msg.
REQ-018 SHALL have port snp_data, input, DATA_W, data of the matched local line.
REQ-019 SHALL have port snp_wb, output, 1, snooper writes back its line.
REQ-020 SHALL have port abort_mem, output, 1, memory access is cancelled because the snooper supplies the data.
REQ-021 SHALL have port snp_hit, output, 1, valid copy exists.
REQ-022 SHALL have port snp_next_state, output, 2, new snooped state.
REQ-023 SHALL have port snp_proc_out, output, PROC_W, registered snp_proc.
REQ-024 SHALL have port snp_data_out, output, DATA_W, data supplied to the bus.

Function
REQ-025 All outputs SHALL be registered and take their values one clock after the strobe is sampled high (latency 1).
REQ-026 When a strobe is low, the corresponding bus_msg, req_wb, snp_wb, abort_mem, and snp_hit outputs SHALL return to 0; the state and proc outputs hold.
REQ-027 Requester, state I: cpu_action 001/010 -> S with bus_msg 001; 011/100 -> M with bus_msg 010. Hit codes received in state I SHALL be treated as misses.
REQ-028 Requester, state S: 001 -> S with bus_msg 000; 010 -> S with bus_msg 001; 011 -> M with bus_msg 011; 100 -> M with bus_msg 010.
REQ-029 Requester, state M: 001/011 -> M with bus_msg 000; 010 -> S with bus_msg 001 and req_wb=1; 100 -> M with bus_msg 010 and req_wb=1.
REQ-030 Undefined cpu_action codes or state 11 SHALL produce next state equal to the current state, with bus_msg 000 and req_wb 0.
REQ-031 Snooper with snp_cache_hit=0 or snp_state I SHALL produce unchanged state and all flags 0.
REQ-032 Snooper, state S: msg 001 -> S; msg 010 or 011 -> I; no writeback.
REQ-033 Snooper, state M: msg 001 -> S with snp_wb=1 and abort_mem=1; msg 010 -> I with snp_wb=1 and abort_mem=1; msg 011 -> I.
REQ-034 snp_hit SHALL equal snp_cache_hit AND (snp_state != I); snp_data_out SHALL be loaded with snp_data whenever abort_mem is set, and hold otherwise.
REQ-035 Simultaneous requester and snooper strobes SHALL be processed independently in the same cycle.

Reset
REQ-036 When reset is asserted, all outputs SHALL be 0 immediately, including states (I) and proc and data outputs.
REQ-037 Reset asserted mid-operation SHALL discard any pending result; the first evaluation after release SHALL follow the normal 1-cycle latency.

Structure
REQ-038 Package msi_pkg SHALL hold the state, cpu_action, and bus-message encodings as typed constants.
REQ-039 The snooper side SHALL be a single sub-module, msi_snoop_side; the requester logic SHALL stay in the top level.

Verification
REQ-040 Read miss from I: req_state=00, cpu_action=010, req_proc=1 -> next cycle req_next_state=01, bus_msg=001, req_proc_out=1, req_wb=0.
REQ-041 Write hit from S: req_state=01, cpu_action=011 -> req_next_state=10, bus_msg=011.
REQ-042 Read miss from M: req_state=10, cpu_action=010 -> req_next_state=01, bus_msg=001, req_wb=1.
REQ-043 Snoop read miss on M: snp_state=10, snp_cache_hit=1, bus_msg_in=001, snp_data=0x37 -> snp_next_state=01, snp_wb=1, abort_mem=1, snp_hit=1, snp_data_out=0x37.
REQ-044 Snoop invalidate on S with both strobes high in the same cycle -> snp_next_state=00 and the requester result is correct in the same cycle.
REQ-045 Reset mid-strobe -> all outputs 0 asynchronously; no stale result appears after reset releases.

Source files
------------

// File: rtl/msi_pkg.sv
// Encodings shared by the MSI requester and snooper logic.
package msi_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_M = 2'b10,
        ST_X = 2'b11
    } msi_state_e;

    typedef enum logic [2:0] {
        CPU_NONE    = 3'b000,
        CPU_RD_HIT  = 3'b001,
        CPU_RD_MISS = 3'b010,
        CPU_WR_HIT  = 3'b011,
        CPU_WR_MISS = 3'b100
    } cpu_action_e;

    typedef enum logic [2:0] {
        BUS_NONE    = 3'b000,
        BUS_RD_MISS = 3'b001,
        BUS_WR_MISS = 3'b010,
        BUS_INV     = 3'b011
    } bus_msg_e;

endpackage

// File: rtl/msi_snoop_side.sv
// Snooper half of the MSI controller: reacts to bus messages against a matched local line.
module msi_snoop_side
    import msi_pkg::*;
#(
    parameter int PROC_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              snp_active,
    input  logic              snp_cache_hit,
    input  logic [1:0]        snp_state,
    input  logic [PROC_W-1:0] snp_proc,
    input  logic [2:0]        bus_msg_in,
    input  logic [DATA_W-1:0] snp_data,
    output logic              snp_wb,
    output logic              abort_mem,
    output logic              snp_hit,
    output logic [1:0]        snp_next_state,
    output logic [PROC_W-1:0] snp_proc_out,
    output logic [DATA_W-1:0] snp_data_out
);

    logic              wb_q, wb_d;
    logic              abort_q, abort_d;
    logic              hit_q, hit_d;
    logic [1:0]        state_q, state_d;
    logic [PROC_W-1:0] proc_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        wb_d    = 1'b0;
        abort_d = 1'b0;
        state_d = snp_state;
        hit_d   = snp_cache_hit && (snp_state != ST_I);
        if (snp_cache_hit) begin
            case (snp_state)
                ST_S: begin
                    if (bus_msg_in == BUS_WR_MISS || bus_msg_in == BUS_INV)
                        state_d = ST_I;
                end
                ST_M: begin
                    // Owner of a dirty line supplies data and keeps memory off the bus.
                    case (bus_msg_in)
                        BUS_RD_MISS: begin
                            state_d = ST_S;
                            wb_d    = 1'b1;
                            abort_d = 1'b1;
                        end
                        BUS_WR_MISS: begin
                            state_d = ST_I;
                            wb_d    = 1'b1;
                            abort_d = 1'b1;
                        end
                        BUS_INV: state_d = ST_I;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_q    <= 1'b0;
            abort_q <= 1'b0;
            hit_q   <= 1'b0;
            state_q <= ST_I;
            proc_q  <= '0;
            data_q  <= '0;
        end else if (snp_active) begin
            wb_q    <= wb_d;
            abort_q <= abort_d;
            hit_q   <= hit_d;
            state_q <= state_d;
            proc_q  <= snp_proc;
            if (abort_d)
                data_q <= snp_data;
        end else begin
            wb_q    <= 1'b0;
            abort_q <= 1'b0;
            hit_q   <= 1'b0;
        end
    end

    assign snp_wb         = wb_q;
    assign abort_mem      = abort_q;
    assign snp_hit        = hit_q;
    assign snp_next_state = state_q;
    assign snp_proc_out   = proc_q;
    assign snp_data_out   = data_q;

endmodule

// File: rtl/msi_snoop_fsm.sv
// MSI coherence controller: requester transitions here, snooper side in msi_snoop_side.
module msi_snoop_fsm
    import msi_pkg::*;
#(
    parameter int PROC_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_active,
    input  logic [2:0]        cpu_action,
    input  logic [1:0]        req_state,
    input  logic [PROC_W-1:0] req_proc,
    output logic              req_wb,
    output logic [1:0]        req_next_state,
    output logic [2:0]        bus_msg,
    output logic [PROC_W-1:0] req_proc_out,
    input  logic              snp_active,
    input  logic              snp_cache_hit,
    input  logic [1:0]        snp_state,
    input  logic [PROC_W-1:0] snp_proc,
    input  logic [2:0]        bus_msg_in,
    input  logic [DATA_W-1:0] snp_data,
    output logic              snp_wb,
    output logic              abort_mem,
    output logic              snp_hit,
    output logic [1:0]        snp_next_state,
    output logic [PROC_W-1:0] snp_proc_out,
    output logic [DATA_W-1:0] snp_data_out
);

    logic              wb_q, wb_d;
    logic [1:0]        state_q, state_d;
    logic [2:0]        msg_q, msg_d;
    logic [PROC_W-1:0] proc_q;

    always_comb begin
        wb_d    = 1'b0;
        msg_d   = BUS_NONE;
        state_d = req_state;
        case (req_state)
            ST_I: begin
                // Without a valid copy, a "hit" can only be serviced as a miss.
                case (cpu_action)
                    CPU_RD_HIT, CPU_RD_MISS: begin
                        state_d = ST_S;
                        msg_d   = BUS_RD_MISS;
                    end
                    CPU_WR_HIT, CPU_WR_MISS: begin
                        state_d = ST_M;
                        msg_d   = BUS_WR_MISS;
                    end
                    default: ;
                endcase
            end
            ST_S: begin
                case (cpu_action)
                    CPU_RD_HIT: state_d = ST_S;
                    CPU_RD_MISS: begin
                        state_d = ST_S;
                        msg_d   = BUS_RD_MISS;
                    end
                    CPU_WR_HIT: begin
                        state_d = ST_M;
                        msg_d   = BUS_INV;
                    end
                    CPU_WR_MISS: begin
                        state_d = ST_M;
                        msg_d   = BUS_WR_MISS;
                    end
                    default: ;
                endcase
            end
            ST_M: begin
                case (cpu_action)
                    CPU_RD_HIT, CPU_WR_HIT: state_d = ST_M;
                    CPU_RD_MISS: begin
                        state_d = ST_S;
                        msg_d   = BUS_RD_MISS;
                        wb_d    = 1'b1;
                    end
                    CPU_WR_MISS: begin
                        state_d = ST_M;
                        msg_d   = BUS_WR_MISS;
                        wb_d    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_q    <= 1'b0;
            state_q <= ST_I;
            msg_q   <= BUS_NONE;
            proc_q  <= '0;
        end else if (req_active) begin
            wb_q    <= wb_d;
            state_q <= state_d;
            msg_q   <= msg_d;
            proc_q  <= req_proc;
        end else begin
            wb_q  <= 1'b0;
            msg_q <= BUS_NONE;
        end
    end

    assign req_wb         = wb_q;
    assign req_next_state = state_q;
    assign bus_msg        = msg_q;
    assign req_proc_out   = proc_q;

    msi_snoop_side #(
        .PROC_W(PROC_W),
        .DATA_W(DATA_W)
    ) u_snoop (
        .clock          (clock),
        .reset          (reset),
        .snp_active     (snp_active),
        .snp_cache_hit  (snp_cache_hit),
        .snp_state      (snp_state),
        .snp_proc       (snp_proc),
        .bus_msg_in     (bus_msg_in),
        .snp_data       (snp_data),
        .snp_wb         (snp_wb),
        .abort_mem      (abort_mem),
        .snp_hit        (snp_hit),
        .snp_next_state (snp_next_state),
        .snp_proc_out   (snp_proc_out),
        .snp_data_out   (snp_data_out)
    );

endmodule

// File: tb/tb_msi_snoop_fsm.sv
// Directed vector bench for msi_snoop_fsm: table of transitions plus reset corner cases.
module tb_msi_snoop_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_active = 1'b0;
    logic [2:0] cpu_action = 3'b000;
    logic [1:0] req_state = 2'b00;
    logic [1:0] req_proc = 2'd0;
    logic       req_wb;
    logic [1:0] req_next_state;
    logic [2:0] bus_msg;
    logic [1:0] req_proc_out;
    logic       snp_active = 1'b0;
    logic       snp_cache_hit = 1'b0;
    logic [1:0] snp_state = 2'b00;
    logic [1:0] snp_proc = 2'd0;
    logic [2:0] bus_msg_in = 3'b000;
    logic [7:0] snp_data = 8'h00;
    logic       snp_wb;
    logic       abort_mem;
    logic       snp_hit;
    logic [1:0] snp_next_state;
    logic [1:0] snp_proc_out;
    logic [7:0] snp_data_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    msi_snoop_fsm #(.PROC_W(2), .DATA_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_active     (req_active),
        .cpu_action     (cpu_action),
        .req_state      (req_state),
        .req_proc       (req_proc),
        .req_wb         (req_wb),
        .req_next_state (req_next_state),
        .bus_msg        (bus_msg),
        .req_proc_out   (req_proc_out),
        .snp_active     (snp_active),
        .snp_cache_hit  (snp_cache_hit),
        .snp_state      (snp_state),
        .snp_proc       (snp_proc),
        .bus_msg_in     (bus_msg_in),
        .snp_data       (snp_data),
        .snp_wb         (snp_wb),
        .abort_mem      (abort_mem),
        .snp_hit        (snp_hit),
        .snp_next_state (snp_next_state),
        .snp_proc_out   (snp_proc_out),
        .snp_data_out   (snp_data_out)
    );

    typedef struct {
        logic       ra;
        logic [2:0] act;
        logic [1:0] rst;
        logic [1:0] rp;
        logic       sa;
        logic       hit;
        logic [1:0] sst;
        logic [1:0] sp;
        logic [2:0] msg;
        logic [7:0] sd;
        logic       e_rwb;
        logic [1:0] e_rns;
        logic [2:0] e_bus;
        logic [1:0] e_rp;
        logic       e_swb;
        logic       e_ab;
        logic       e_sh;
        logic [1:0] e_sns;
        logic [1:0] e_sp;
        logic [7:0] e_sd;
    } vec_t;

    localparam int NV = 17;
    vec_t tv[NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_rwb, input logic [1:0] e_rns, input logic [2:0] e_bus,
                           input logic [1:0] e_rp, input logic e_swb, input logic e_ab, input logic e_sh,
                           input logic [1:0] e_sns, input logic [1:0] e_sp, input logic [7:0] e_sd);
        chk("req_wb", idx, 32'(req_wb), 32'(e_rwb));
        chk("req_next_state", idx, 32'(req_next_state), 32'(e_rns));
        chk("bus_msg", idx, 32'(bus_msg), 32'(e_bus));
        chk("req_proc_out", idx, 32'(req_proc_out), 32'(e_rp));
        chk("snp_wb", idx, 32'(snp_wb), 32'(e_swb));
        chk("abort_mem", idx, 32'(abort_mem), 32'(e_ab));
        chk("snp_hit", idx, 32'(snp_hit), 32'(e_sh));
        chk("snp_next_state", idx, 32'(snp_next_state), 32'(e_sns));
        chk("snp_proc_out", idx, 32'(snp_proc_out), 32'(e_sp));
        chk("snp_data_out", idx, 32'(snp_data_out), 32'(e_sd));
    endtask

    task automatic drive(input vec_t v);
        req_active    = v.ra;
        cpu_action    = v.act;
        req_state     = v.rst;
        req_proc      = v.rp;
        snp_active    = v.sa;
        snp_cache_hit = v.hit;
        snp_state     = v.sst;
        snp_proc      = v.sp;
        bus_msg_in    = v.msg;
        snp_data      = v.sd;
    endtask

    task automatic idle();
        req_active = 1'b0;
        snp_active = 1'b0;
    endtask

    initial begin
        // Expected outputs hold state/proc/data from earlier steps when a strobe is low.
        tv[0]  = '{1'b1,3'b010,2'b00,2'd1, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b01,3'b001,2'd1, 1'b0,1'b0,1'b0,2'b00,2'd0,8'h00};
        tv[1]  = '{1'b1,3'b011,2'b01,2'd2, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b10,3'b011,2'd2, 1'b0,1'b0,1'b0,2'b00,2'd0,8'h00};
        tv[2]  = '{1'b1,3'b010,2'b10,2'd3, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b1,2'b01,3'b001,2'd3, 1'b0,1'b0,1'b0,2'b00,2'd0,8'h00};
        tv[3]  = '{1'b0,3'b000,2'b00,2'd0, 1'b1,1'b1,2'b10,2'd2,3'b001,8'h37, 1'b0,2'b01,3'b000,2'd3, 1'b1,1'b1,1'b1,2'b01,2'd2,8'h37};
        tv[4]  = '{1'b1,3'b100,2'b01,2'd0, 1'b1,1'b1,2'b01,2'd1,3'b011,8'hAA, 1'b0,2'b10,3'b010,2'd0, 1'b0,1'b0,1'b1,2'b00,2'd1,8'h37};
        tv[5]  = '{1'b1,3'b100,2'b10,2'd1, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h55, 1'b1,2'b10,3'b010,2'd1, 1'b0,1'b0,1'b0,2'b00,2'd1,8'h37};
        tv[6]  = '{1'b1,3'b001,2'b00,2'd2, 1'b1,1'b1,2'b10,2'd3,3'b010,8'hC3, 1'b0,2'b01,3'b001,2'd2, 1'b1,1'b1,1'b1,2'b00,2'd3,8'hC3};
        tv[7]  = '{1'b1,3'b011,2'b00,2'd3, 1'b1,1'b0,2'b10,2'd0,3'b001,8'hFF, 1'b0,2'b10,3'b010,2'd3, 1'b0,1'b0,1'b0,2'b10,2'd0,8'hC3};
        tv[8]  = '{1'b1,3'b001,2'b01,2'd0, 1'b1,1'b1,2'b00,2'd1,3'b001,8'h11, 1'b0,2'b01,3'b000,2'd0, 1'b0,1'b0,1'b0,2'b00,2'd1,8'hC3};
        tv[9]  = '{1'b1,3'b001,2'b10,2'd1, 1'b1,1'b1,2'b10,2'd2,3'b011,8'h22, 1'b0,2'b10,3'b000,2'd1, 1'b0,1'b0,1'b1,2'b00,2'd2,8'hC3};
        tv[10] = '{1'b1,3'b011,2'b10,2'd2, 1'b1,1'b1,2'b01,2'd3,3'b001,8'h33, 1'b0,2'b10,3'b000,2'd2, 1'b0,1'b0,1'b1,2'b01,2'd3,8'hC3};
        tv[11] = '{1'b1,3'b010,2'b01,2'd3, 1'b1,1'b1,2'b01,2'd0,3'b010,8'h44, 1'b0,2'b01,3'b001,2'd3, 1'b0,1'b0,1'b1,2'b00,2'd0,8'hC3};
        tv[12] = '{1'b1,3'b000,2'b01,2'd0, 1'b1,1'b1,2'b10,2'd1,3'b000,8'h66, 1'b0,2'b01,3'b000,2'd0, 1'b0,1'b0,1'b1,2'b10,2'd1,8'hC3};
        tv[13] = '{1'b1,3'b111,2'b10,2'd1, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b10,3'b000,2'd1, 1'b0,1'b0,1'b0,2'b10,2'd1,8'hC3};
        tv[14] = '{1'b1,3'b010,2'b11,2'd2, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b11,3'b000,2'd2, 1'b0,1'b0,1'b0,2'b10,2'd1,8'hC3};
        tv[15] = '{1'b0,3'b001,2'b00,2'd3, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b11,3'b000,2'd2, 1'b0,1'b0,1'b0,2'b10,2'd1,8'hC3};
        tv[16] = '{1'b1,3'b101,2'b00,2'd3, 1'b0,1'b0,2'b00,2'd0,3'b000,8'h00, 1'b0,2'b00,3'b000,2'd3, 1'b0,1'b0,1'b0,2'b10,2'd1,8'hC3};

        // Outputs are zero while reset is held.
        repeat (2) @(posedge clock);
        #1;
        chk_all(-1, 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(tv[i]);
            @(posedge clock);
            #1;
            chk_all(i, tv[i].e_rwb, tv[i].e_rns, tv[i].e_bus, tv[i].e_rp, tv[i].e_swb,
                    tv[i].e_ab, tv[i].e_sh, tv[i].e_sns, tv[i].e_sp, tv[i].e_sd);
        end

        // Reset mid-strobe: load a result, then assert reset between clock edges.
        @(negedge clock);
        req_active = 1'b1; cpu_action = 3'b100; req_state = 2'b00; req_proc = 2'd2;
        snp_active = 1'b1; snp_cache_hit = 1'b1; snp_state = 2'b10; snp_proc = 2'd3;
        bus_msg_in = 3'b001; snp_data = 8'h5A;
        @(posedge clock);
        #1;
        chk_all(100, 1'b0, 2'b10, 3'b010, 2'd2, 1'b1, 1'b1, 1'b1, 2'b01, 2'd3, 8'h5A);
        #2;
        reset = 1'b1;
        #1;
        chk_all(101, 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00);
        @(negedge clock);
        idle();
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_all(102, 1'b0, 2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00);

        // First evaluation after release: nothing visible before the edge, result one clock later.
        @(negedge clock);
        req_active = 1'b1; cpu_action = 3'b010; req_state = 2'b00; req_proc = 2'd1;
        #1;
        chk("pre_edge bus_msg", 103, 32'(bus_msg), 32'd0);
        chk("pre_edge req_next_state", 103, 32'(req_next_state), 32'd0);
        @(posedge clock);
        #1;
        chk_all(104, 1'b0, 2'b01, 3'b001, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00);
        @(negedge clock);
        idle();
        @(posedge clock);
        #1;
        chk_all(105, 1'b0, 2'b01, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
